// File: rtl/csa_seq_ctrl.sv
// Feeds W-bit operand pairs LSB-first into a bit-serial adder and collects the W+1-bit sum.
// Latency: handshake to out_valid is W+3 cycles; in_ready is low from acceptance until the result is taken.
module csa_seq_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   out_sum,
  output logic         busy,
  output logic         add_clr,
  output logic         add_x,
  output logic         add_y,
  input  logic         add_sum
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {FLUSH, IDLE, RUN, DRAIN, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   a_sr;
  logic [W-1:0]   b_sr;
  logic [W:0]     res;
  logic [W:0]     res_nxt;

  assign res_nxt = {add_sum, res[W:1]};

  // Outputs are registered, so each branch sets the values for the state being entered.
  // a_sr/b_sr therefore run one bit ahead of the bit currently presented to the adder.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FLUSH;
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      res       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      busy      <= 1'b1;
      add_clr   <= 1'b0;
      add_x     <= 1'b0;
      add_y     <= 1'b0;
    end else begin
      case (state)
        FLUSH: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          add_clr  <= 1'b1;
        end
        IDLE: begin
          if (in_valid) begin
            state    <= RUN;
            cnt      <= '0;
            a_sr     <= in_a >> 1;
            b_sr     <= in_b >> 1;
            add_x    <= in_a[0];
            add_y    <= in_b[0];
            add_clr  <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state   <= FLUSH;
            cnt     <= '0;
            add_x   <= 1'b0;
            add_y   <= 1'b0;
            add_clr <= 1'b0;
          end else begin
            if (cnt != '0) res <= res_nxt;
            cnt  <= cnt + CW'(1);
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            if (cnt == CW'(W)) begin
              state   <= DRAIN;
              add_clr <= 1'b1;
              add_x   <= 1'b0;
              add_y   <= 1'b0;
            end else begin
              // Zero-filled shifters give the x=y=0 carry-flush bit at cnt==W.
              add_x <= a_sr[0];
              add_y <= b_sr[0];
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state   <= FLUSH;
            cnt     <= '0;
            add_clr <= 1'b0;
          end else begin
            state     <= DONE;
            res       <= res_nxt;
            out_sum   <= res_nxt;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state    <= FLUSH;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          add_clr  <= 1'b0;
          add_x    <= 1'b0;
          add_y    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_seq_ctrl.sv
// Drives csa_seq_ctrl against a behavioural bit-serial adder and checks results, timing and abort/reset handling.
module tb_csa_seq_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_sum;
  logic         busy;
  logic         add_clr;
  logic         add_x;
  logic         add_y;
  logic         add_sum;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  csa_seq_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .busy(busy), .add_clr(add_clr), .add_x(add_x), .add_y(add_y), .add_sum(add_sum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Serial adder: clr zeroes only the sum and freezes the carry.
  logic carry;
  always @(posedge clk) begin
    if (add_clr) begin
      add_sum <= 1'b0;
    end else begin
      add_sum <= add_x ^ add_y ^ carry;
      carry   <= (add_x & add_y) | (add_x & carry) | (add_y & carry);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Handshake an operand pair, wait for the result, optionally stall the consumer, then release it.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    logic [W:0] exp_sum;
    logic [W:0] held;
    int c0;
    int n;
    exp_sum = {1'b0, a} + {1'b0, b};
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_valid = 1'b1;
    abort = 1'($urandom_range(0, 1));
    c0 = cyc;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom);
    chk("in_ready_after_hs", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      @(negedge clk); n++;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
    chk("latency", 32'(cyc - c0), 32'(W + 3));
    chk("sum", 32'(out_sum), 32'(exp_sum));
    held = out_sum;
    for (int i = 0; i < stall; i++) begin
      abort = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_sum", 32'(out_sum), 32'(held));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    abort = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_idle", 32'(in_ready), 32'd1);
  endtask

  // Start an operation and kill it with abort (or rst) while cnt==k; k==W+1 lands in DRAIN.
  task automatic run_kill(input logic [W-1:0] a, input logic [W-1:0] b, input int k, input bit use_rst);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("kill_in_ready_wait", 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < k; i++) begin
      chk("kill_no_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    if (use_rst) rst = 1'b1; else abort = 1'b1;
    @(negedge clk);
    rst = 1'b0; abort = 1'b0;
    chk("kill_flush_ready", 32'(in_ready), 32'd0);
    chk("kill_flush_busy", 32'(busy), 32'd1);
    chk("kill_flush_valid", 32'(out_valid), 32'd0);
    chk("kill_flush_x", 32'({add_x, add_y, add_clr}), 32'd0);
    if (use_rst) chk("kill_rst_sum", 32'(out_sum), 32'd0);
    @(negedge clk);
    chk("kill_idle_ready", 32'(in_ready), 32'd1);
    chk("kill_idle_busy", 32'(busy), 32'd0);
    chk("kill_idle_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; abort = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    rst = 1'b0;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_out_sum", 32'(out_sum), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    run_op(8'h5A, 8'h3C, 0);
    run_op(8'hFF, 8'h01, 0);
    run_op(8'h00, 8'h00, 0);
    run_op(8'hC3, 8'h7E, 5);
    run_kill(8'hFF, 8'hFF, 4, 1'b0);
    run_op(8'h01, 8'h01, 0);
    run_kill(8'hAA, 8'h55, 3, 1'b1);
    run_op(8'h80, 8'h80, 0);
    run_kill(8'hFF, 8'hFF, W + 1, 1'b0);
    run_op(8'h00, 8'h00, 1);

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 4) == 0)
        run_kill(W'($urandom), W'($urandom), $urandom_range(0, W + 1), 1'($urandom_range(0, 1)));
      run_op(W'($urandom), W'($urandom), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
